// File: rtl/wimuse_pkg.sv
// Shared types, port/code constants and address decode for the WiMuse capture path.
// WIMUSE_TEST_ADDR_EN additionally accepts test ports 0x00/0x01 as codes 000/001.
package wimuse_pkg;

  localparam logic [7:0] PORT_TEST_A = 8'h00;
  localparam logic [7:0] PORT_TEST_D = 8'h01;
  localparam logic [7:0] PORT_OPLL_A = 8'h7C;
  localparam logic [7:0] PORT_OPLL_D = 8'h7D;
  localparam logic [7:0] PORT_PSG_A  = 8'hA0;
  localparam logic [7:0] PORT_PSG_D  = 8'hA1;
  localparam logic [7:0] PORT_AUD_A  = 8'hC0;
  localparam logic [7:0] PORT_AUD_D  = 8'hC1;

  localparam logic [2:0] CODE_TEST_A = 3'b000;
  localparam logic [2:0] CODE_TEST_D = 3'b001;
  localparam logic [2:0] CODE_OPLL_A = 3'b010;
  localparam logic [2:0] CODE_OPLL_D = 3'b011;
  localparam logic [2:0] CODE_PSG_A  = 3'b100;
  localparam logic [2:0] CODE_PSG_D  = 3'b101;
  localparam logic [2:0] CODE_AUD_A  = 3'b110;
  localparam logic [2:0] CODE_AUD_D  = 3'b111;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DECODE,
    W_PUSH
  } wstate_t;

  typedef struct packed {
    logic [2:0] ct;
    logic [2:0] ad;
    logic [7:0] dt;
  } entry_t;

  // Returns {valid, code}; unknown ports come back as all zeros.
  function automatic logic [3:0] decode(input logic [7:0] addr);
    logic [3:0] res;
    res = 4'b0000;
    case (addr)
      PORT_OPLL_A: res = {1'b1, CODE_OPLL_A};
      PORT_OPLL_D: res = {1'b1, CODE_OPLL_D};
      PORT_PSG_A:  res = {1'b1, CODE_PSG_A};
      PORT_PSG_D:  res = {1'b1, CODE_PSG_D};
      PORT_AUD_A:  res = {1'b1, CODE_AUD_A};
      PORT_AUD_D:  res = {1'b1, CODE_AUD_D};
`ifdef WIMUSE_TEST_ADDR_EN
      PORT_TEST_A: res = {1'b1, CODE_TEST_A};
      PORT_TEST_D: res = {1'b1, CODE_TEST_D};
`endif
      default:     res = 4'b0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wimuse_sync_edge.sv
// Synchronizes an async active-low strobe and emits a one-cycle pulse on its falling edge.
// Pulse appears SYNC_STAGES edges after the first edge that samples the strobe low.
module wimuse_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic fall_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  // Reset to 0 so a strobe already low at release never produces a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign fall_pulse = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/wimuse_capture_ctrl.sv
// Captures decoded MSX sound-port writes into a ring buffer popped by the ESP strobe.
// esp_rdy rises SYNC_STAGES+4 edges after msx_req is sampled low; full buffer drops and sets sticky ovf (WIMUSE_TEST_ADDR_EN in pkg).
module wimuse_capture_ctrl
  import wimuse_pkg::*;
#(
  parameter int DEPTH_LOG2  = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  msx_req,
  input  logic [7:0]            msx_ad,
  input  logic [7:0]            msx_dt,
  input  logic                  esp_req,
  output logic [2:0]            esp_ct,
  output logic [2:0]            esp_ad,
  output logic [7:0]            esp_dt,
  output logic                  esp_rdy,
  output logic                  ovf,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);

  logic                  msx_fall, esp_fall;
  wstate_t               state_q, state_d;
  logic                  latch_en, push_req;
  logic [7:0]            ad_q, dt_q;
  logic [3:0]            dec;
  logic                  pop, room, push, drop;
  logic [DEPTH_LOG2-1:0] wp_q, rp_q;
  logic [2:0]            ct_q;
  entry_t                new_entry;
  entry_t                mem [DEPTH];

  wimuse_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_msx_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (msx_req),
    .fall_pulse (msx_fall)
  );

  wimuse_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_esp_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (esp_req),
    .fall_pulse (esp_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= W_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      W_IDLE:   if (msx_fall) state_d = W_DECODE;
      W_DECODE: state_d = dec[3] ? W_PUSH : W_IDLE;
      W_PUSH:   state_d = W_IDLE;
      default:  state_d = W_IDLE;
    endcase
  end

  always_comb begin
    latch_en = (state_q == W_IDLE) && msx_fall;
    push_req = (state_q == W_PUSH);
  end

  assign dec       = decode(ad_q);
  assign pop       = esp_fall && (level != '0);
  // A same-cycle pop frees a slot, so a full buffer can still take the push.
  assign room      = (level < FULL_LVL) || pop;
  assign push      = push_req && room;
  assign drop      = push_req && !room;
  assign new_entry = '{ct: ct_q + 3'd1, ad: dec[2:0], dt: dt_q};

  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= new_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ad_q    <= '0;
      dt_q    <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      ct_q    <= '0;
      level   <= '0;
      ovf     <= 1'b0;
      esp_ct  <= '0;
      esp_ad  <= '0;
      esp_dt  <= '0;
      esp_rdy <= 1'b0;
    end else begin
      if (latch_en) begin
        ad_q <= msx_ad;
        dt_q <= msx_dt;
      end
      if (push) begin
        wp_q <= wp_q + 1'b1;
        ct_q <= ct_q + 3'd1;
      end
      if (pop) rp_q <= rp_q + 1'b1;
      if (drop) ovf <= 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // Head follows mem[rp] only while non-empty, so the last popped entry stays visible.
      if (level != '0) begin
        esp_ct <= mem[rp_q].ct;
        esp_ad <= mem[rp_q].ad;
        esp_dt <= mem[rp_q].dt;
      end
      esp_rdy <= (level != '0);
    end
  end

endmodule

// File: tb/tb_wimuse_capture_ctrl.sv
// Scoreboard bench: expected entries queued per write, compared against the head before each pop.
module tb_wimuse_capture_ctrl;

  localparam int SS = 2;
  localparam int DL = 5;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          msx_req = 1'b1;
  logic [7:0]    msx_ad = '0;
  logic [7:0]    msx_dt = '0;
  logic          esp_req = 1'b1;
  logic [2:0]    esp_ct, esp_ad;
  logic [7:0]    esp_dt;
  logic          esp_rdy, ovf;
  logic [DL:0]   level;

  int            n_tests = 0;
  int            n_fail = 0;
  logic [13:0]   sb_q[$];
  logic [2:0]    m_ct = '0;
  logic          m_ovf = 1'b0;
  logic [13:0]   last_pop = '0;
  logic [7:0]    chip_ports [6] = '{8'h7C, 8'h7D, 8'hA0, 8'hA1, 8'hC0, 8'hC1};

  wimuse_capture_ctrl #(.DEPTH_LOG2(DL), .SYNC_STAGES(SS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .msx_req (msx_req),
    .msx_ad  (msx_ad),
    .msx_dt  (msx_dt),
    .esp_req (esp_req),
    .esp_ct  (esp_ct),
    .esp_ad  (esp_ad),
    .esp_dt  (esp_dt),
    .esp_rdy (esp_rdy),
    .ovf     (ovf),
    .level   (level)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_dec(input logic [7:0] a);
    case (a)
      8'h7C: return 4'b1010;
      8'h7D: return 4'b1011;
      8'hA0: return 4'b1100;
      8'hA1: return 4'b1101;
      8'hC0: return 4'b1110;
      8'hC1: return 4'b1111;
`ifdef WIMUSE_TEST_ADDR_EN
      8'h00: return 4'b1000;
      8'h01: return 4'b1001;
`endif
      default: return 4'b0000;
    endcase
  endfunction

  task automatic status(input string tag);
    chk({tag, "_level"}, 32'(level), 32'(sb_q.size()));
    chk({tag, "_rdy"}, 32'(esp_rdy), 32'(sb_q.size() != 0));
    chk({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
  endtask

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    logic [3:0] v;
    v = ref_dec(a);
    if (v[3]) begin
      if (sb_q.size() < DEPTH) begin
        m_ct = m_ct + 3'd1;
        sb_q.push_back({m_ct, v[2:0], d});
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    msx_req = 1'b1;
    esp_req = 1'b1;
    sb_q.delete();
    m_ct = '0;
    m_ovf = 1'b0;
    last_pop = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic msx_write(input logic [7:0] a, input logic [7:0] d, input bit lat);
    model_write(a, d);
    @(negedge clk);
    msx_ad = a;
    msx_dt = d;
    msx_req = 1'b0;
    if (lat) begin
      repeat (SS + 3) @(posedge clk);
      #1 chk("lat_before", 32'(esp_rdy), 32'd0);
      @(posedge clk);
      #1 chk("lat_rdy", 32'(esp_rdy), 32'd1);
      chk("lat_head", 32'({esp_ct, esp_ad, esp_dt}), 32'(sb_q[0]));
      repeat (2) @(posedge clk);
    end else begin
      repeat (SS + 6) @(posedge clk);
    end
    @(negedge clk);
    msx_req = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic esp_pop();
    if (sb_q.size() != 0) begin
      last_pop = sb_q.pop_front();
      chk("head", 32'({esp_ct, esp_ad, esp_dt}), 32'(last_pop));
    end
    @(negedge clk);
    esp_req = 1'b0;
    repeat (6) @(negedge clk);
    esp_req = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // esp_req falls two cycles after msx_req so its pop lands on the W_PUSH edge.
  task automatic push_pop_together(input logic [7:0] a, input logic [7:0] d);
    last_pop = sb_q.pop_front();
    chk("pp_head", 32'({esp_ct, esp_ad, esp_dt}), 32'(last_pop));
    model_write(a, d);
    @(negedge clk);
    msx_ad = a;
    msx_dt = d;
    msx_req = 1'b0;
    repeat (2) @(negedge clk);
    esp_req = 1'b0;
    repeat (8) @(negedge clk);
    msx_req = 1'b1;
    esp_req = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    do_reset();
    chk("rst_ct", 32'(esp_ct), 32'd0);
    chk("rst_ad", 32'(esp_ad), 32'd0);
    chk("rst_dt", 32'(esp_dt), 32'd0);
    status("rst");

    msx_write(8'h7C, 8'h12, 1'b1);
    chk("w1_head", 32'({esp_ct, esp_ad, esp_dt}), 32'({3'd1, 3'b010, 8'h12}));
    status("w1");
    esp_pop();
    status("p1");
    chk("p1_hold", 32'({esp_ct, esp_ad, esp_dt}), 32'({3'd1, 3'b010, 8'h12}));

    do_reset();
    msx_write(8'h55, 8'hAA, 1'b0);
    status("bad_port");
    msx_write(8'hA1, 8'h3F, 1'b0);
    chk("psg_head", 32'({esp_ct, esp_ad, esp_dt}), 32'({3'd1, 3'b101, 8'h3F}));
    status("psg");
    esp_pop();

    msx_write(8'h00, 8'h77, 1'b0);
    status("test_port");
    while (sb_q.size() != 0) esp_pop();

    esp_pop();
    status("empty_pop");
    chk("empty_hold", 32'({esp_ct, esp_ad, esp_dt}), 32'(last_pop));

    for (int i = 0; i < DEPTH; i++) msx_write(chip_ports[i % 6], 8'(i * 7 + 3), 1'b0);
    status("full");
    push_pop_together(8'hC1, 8'hE5);
    status("pp");
    msx_write(8'h7D, 8'h99, 1'b0);
    status("ovf");
    for (int i = 0; i < DEPTH; i++) esp_pop();
    status("drained");

    @(negedge clk);
    msx_ad = 8'hC0;
    msx_dt = 8'h5A;
    msx_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    m_ct = '0;
    m_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    status("rst_held_low");
    msx_req = 1'b1;
    repeat (3) @(negedge clk);
    msx_write(8'hC0, 8'h5A, 1'b0);
    chk("post_rst_head", 32'({esp_ct, esp_ad, esp_dt}), 32'({3'd1, 3'b110, 8'h5A}));
    status("post_rst");
    esp_pop();
    status("end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wimuse_capture_ctrl.md
Name: wimuse_capture_ctrl

Overview:
- Clocked controller for the WiMuse sound-write capture path.
- Samples the asynchronous MSX I/O write strobe and the ESP pop strobe in a single clock domain.
- Decodes sound-chip port addresses and sequences pushes into an internal ring buffer.
- Presents the head entry to the ESP side with ready and overflow status.

Parameters:
- DEPTH_LOG2, 5, log2 of ring-buffer entries (default 32 entries).
- SYNC_STAGES, 2, synchronizer flop count per async strobe (min 2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- msx_req  in  1  async MSX write strobe, active low; a write is committed on its falling edge
- msx_ad  in  8  MSX I/O port address; stable while msx_req low
- msx_dt  in  8  MSX write data; stable while msx_req low
- esp_req  in  1  async ESP pop strobe; each falling edge pops one entry
- esp_ct  out  3  sequence tag of head entry
- esp_ad  out  3  decoded port code of head entry
- esp_dt  out  8  data of head entry
- esp_rdy  out  1  buffer non-empty
- ovf  out  1  sticky overflow flag
- level  out  DEPTH_LOG2+1  current entry count

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values:
  - All outputs 0.
  - Read/write pointers, level, sequence counter and ovf cleared.
  - Write FSM forced to W_IDLE.
  - Synchronizer and edge-delay flops reset to 0.
  - Consequence: a strobe already low at reset release is ignored; msx_req/esp_req must go high, then low, to be seen.
- Strobe capture: each strobe passes SYNC_STAGES flops plus one delay flop. A falling edge is sync-output 0 with delay-flop 1, giving a one-cycle pulse.
- Timing requirement: msx_req and esp_req low time ≥ SYNC_STAGES+3 clk periods. msx_ad/msx_dt are sampled while still low.
- Address decode (valid, code):
  - 0x7C → 010, 0x7D → 011 (OPLL address / data)
  - 0xA0 → 100, 0xA1 → 101 (PSG address / data)
  - 0xC0 → 110, 0xC1 → 111 (MSX-AUDIO address / data)
  - 0x00 → 000, 0x01 → 001 (test ports; see Optional Feature)
  - Anything else: invalid.
- Write FSM:
  - W_IDLE: on msx falling-edge pulse, latch msx_ad/msx_dt → W_DECODE.
  - W_DECODE: if invalid → W_IDLE, nothing stored. If valid → W_PUSH.
  - W_PUSH: if there is room, write {ct+1, code, data} at wp; wp++; ct++ (3-bit wrap 7→0). If full, drop the entry, set ovf, leave ct unchanged. Always → W_IDLE.
  - Room test: level < 2^DEPTH_LOG2, OR a pop occurs in the same cycle.
- Read side:
  - An esp falling-edge pulse pops when level ≠ 0, evaluated on the pre-cycle level. rp++.
  - A pop on empty is ignored, with no error flag.
- Simultaneous push and pop: both performed; level unchanged; a full buffer still accepts the push.
- Pointer and level rules: pointers are DEPTH_LOG2 bits and wrap naturally; level is DEPTH_LOG2+1 bits.
- Outputs:
  - esp_ct/esp_ad/esp_dt are registered copies of mem[rp], updated the cycle after rp or the head write changes.
  - When empty they hold the last popped entry's values (0 after reset).
  - esp_rdy is a registered (level ≠ 0).
- Latency: esp_rdy rises SYNC_STAGES+4 clk edges after the first edge sampling msx_req low into an empty buffer. The head fields are valid by the same edge.
- ovf: cleared only by reset.

Optional Feature:
- Macro: WIMUSE_TEST_ADDR_EN.
- Defined: ports 0x00/0x01 decode valid as codes 000/001.
- Undefined: 0x00/0x01 are invalid and dropped in W_DECODE. Only the six chip ports are captured.

Decomposition:
- Package wimuse_pkg:
  - Localparams for the eight port addresses and 3-bit codes.
  - Write-FSM state enum typedef.
  - Entry struct typedef {ct[2:0], ad[2:0], dt[7:0]}.
  - decode function returning {valid, code}.
- Sub-module wimuse_sync_edge: parameter SYNC_STAGES; ports clk, rst_n, async_in → fall_pulse. Instantiated twice, for msx_req and esp_req.

Test Plan:
- Reset, then a write to 0x7C with 0x12: esp_rdy=1 SYNC_STAGES+4 edges after msx_req low; esp_ct=1, esp_ad=010, esp_dt=0x12, level=1. Then one esp_req pulse: esp_rdy=0, level=0, outputs hold the entry.
- Write to 0x55 with 0xAA: no entry, level stays 0, ct unchanged. Next write to 0xA1 with 0x3F: esp_ct=1, esp_ad=101.
- 33 valid writes with no pops (DEPTH_LOG2=5): level=32, ovf=1, 33rd entry dropped. Popping all 32 returns ct 1..7,0,1,... in order.
- A pop pulse and the W_PUSH cycle coinciding while level=32: push accepted, level stays 32, ovf stays 0.
- rst_n asserted mid-strobe with msx_req held low through release: no capture. Subsequent high→low strobe captured with ct=1.
- WIMUSE_TEST_ADDR_EN undefined: write to 0x00 produces no entry. Defined: produces esp_ad=000.
